// File: rtl/pc_pkg.sv
// Shared encodings for the PC sequencer: next-PC source select, trap cause
// and the sequencer FSM states.
package pc_pkg;

  typedef enum logic [2:0] {
    PC_SEQ    = 3'd0,
    PC_BRANCH = 3'd1,
    PC_JUMP   = 3'd2,
    PC_REG    = 3'd3,
    PC_EPC    = 3'd4
  } pc_src_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_EXT      = 2'd1,
    CAUSE_MISALIGN = 2'd2
  } cause_t;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } pc_state_t;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC candidate and alignment check. Reserved selects
// (5-7) fall back to the sequential address.
module pc_next_calc
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned INC   = 4
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] epc,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  input  logic [2:0]       pc_src,
  output logic [WIDTH-1:0] cand,
  output logic             misaligned
);

  localparam logic [WIDTH-1:0] INC_W  = WIDTH'(INC);
  localparam logic [WIDTH-1:0] MASK_W = WIDTH'(INC - 1);

  logic [WIDTH-1:0] seq;

  // Select candidate; all arithmetic wraps modulo 2^WIDTH. The multiply by
  // INC wraps identically for a signed or unsigned offset.
  always_comb begin
    seq  = pc + INC_W;
    cand = seq;
    case (pc_src)
      PC_BRANCH:     cand = seq + (offset * INC_W);
      PC_JUMP,
      PC_REG:        cand = target;
      PC_EPC:        cand = epc;
      default:       cand = seq;
    endcase
  end

  // Alignment is modulo INC, which is a power of two.
  assign misaligned = (cand & MASK_W) != '0;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds PC/EPC/cause, loads the next PC on
// pc_write and runs a HOLD/RUN/TRAP FSM for reset hold and two-edge
// exception entry. All outputs are registered.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'('h100),
  parameter int unsigned     INC          = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_write,
  input  logic [2:0]       pc_src,
  input  logic [WIDTH-1:0] offset,
  input  logic [WIDTH-1:0] target,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] epc,
  output logic [1:0]       cause
);

  pc_state_t        state;
  logic [WIDTH-1:0] cand;
  logic             misaligned;

  pc_next_calc #(.WIDTH(WIDTH), .INC(INC)) u_calc (
    .pc         (pc),
    .epc        (epc),
    .offset     (offset),
    .target     (target),
    .pc_src     (pc_src),
    .cand       (cand),
    .misaligned (misaligned)
  );

  // FSM plus PC/EPC/cause registers. In RUN, exc_req beats a misaligned
  // write, which beats a normal write; HOLD and TRAP ignore both inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_HOLD;
      pc       <= RESET_VECTOR;
      epc      <= '0;
      cause    <= CAUSE_NONE;
      pc_valid <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          state    <= ST_RUN;
          pc_valid <= 1'b1;
        end
        ST_RUN: begin
          if (exc_req) begin
            state    <= ST_TRAP;
            epc      <= pc;
            cause    <= CAUSE_EXT;
            pc_valid <= 1'b0;
          end else if (pc_write && misaligned) begin
            state    <= ST_TRAP;
            epc      <= pc;
            cause    <= CAUSE_MISALIGN;
            pc_valid <= 1'b0;
          end else if (pc_write) begin
            pc <= cand;
          end
        end
        ST_TRAP: begin
          state    <= ST_RUN;
          pc       <= EXC_VECTOR;
          pc_valid <= 1'b1;
        end
        default: begin
          state    <= ST_HOLD;
          pc_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters; expected values
// are hand-computed constants.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_write;
  logic [2:0]  pc_src;
  logic [31:0] offset;
  logic [31:0] target;
  logic        exc_req;
  logic [31:0] pc;
  logic        pc_valid;
  logic [31:0] epc;
  logic [1:0]  cause;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .pc_write (pc_write),
    .pc_src   (pc_src),
    .offset   (offset),
    .target   (target),
    .exc_req  (exc_req),
    .pc       (pc),
    .pc_valid (pc_valid),
    .epc      (epc),
    .cause    (cause)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs, clock one edge, settle past the edge.
  task automatic step(input logic r, input logic w, input logic [2:0] s,
                      input logic [31:0] off, input logic [31:0] tgt, input logic x);
    rst = r; pc_write = w; pc_src = s; offset = off; target = tgt; exc_req = x;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic e_vld,
                         input logic [31:0] e_epc, input logic [1:0] e_cause);
    chk({tag, ".pc"},    pc,              e_pc);
    chk({tag, ".vld"},   32'(pc_valid),   32'(e_vld));
    chk({tag, ".epc"},   epc,             e_epc);
    chk({tag, ".cause"}, 32'(cause),      32'(e_cause));
  endtask

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 1);
    chk_all("reset", 32'h0, 0, 32'h0, 0);

    // First edge out of reset: write ignored, pc_valid rises
    step(0, 1, 0, 0, 0, 0);
    chk_all("hold", 32'h0, 1, 32'h0, 0);

    // Five SEQ writes
    for (int i = 1; i <= 5; i++) begin
      step(0, 1, 0, 0, 0, 0);
      chk($sformatf("seq%0d", i), pc, 32'(4 * i));
    end

    // No write holds PC
    step(0, 0, 2, 0, 32'h1234, 0);
    chk("nowrite", pc, 32'd20);

    // Branch back by 3 words from 0x40 -> 0x38
    step(0, 1, 2, 0, 32'h40, 0);
    chk("jmp40", pc, 32'h40);
    step(0, 1, 1, 32'hFFFF_FFFD, 0, 0);
    chk("branch", pc, 32'h38);
    step(0, 1, 2, 0, 32'h1000, 0);
    chk("jump", pc, 32'h1000);

    // Reserved select behaves as SEQ
    step(0, 1, 5, 0, 32'h40, 0);
    chk("reserved", pc, 32'h1004);

    // Misaligned REG target from 0x200
    step(0, 1, 2, 0, 32'h200, 0);
    step(0, 1, 3, 0, 32'h202, 0);
    chk_all("mis.e1", 32'h200, 0, 32'h200, 2);
    step(0, 1, 3, 0, 32'h202, 0);
    chk_all("mis.e2", 32'h100, 1, 32'h200, 2);

    // External exception plus simultaneous write at 0x80; exc_req held in TRAP
    step(0, 1, 2, 0, 32'h80, 0);
    step(0, 1, 0, 0, 0, 1);
    chk_all("exc.e1", 32'h80, 0, 32'h80, 1);
    step(0, 1, 0, 0, 0, 1);
    chk_all("exc.e2", 32'h100, 1, 32'h80, 1);
    step(0, 1, 4, 0, 0, 0);
    chk_all("eret", 32'h80, 1, 32'h80, 1);

    // Wrap-around is silent
    step(0, 1, 2, 0, 32'hFFFF_FFFC, 0);
    step(0, 1, 0, 0, 0, 0);
    chk_all("wrap", 32'h0, 1, 32'h80, 1);

    // Reset on the TRAP cycle
    step(0, 1, 2, 0, 32'h300, 0);
    step(0, 0, 0, 0, 0, 1);
    chk_all("trap", 32'h300, 0, 32'h300, 1);
    step(1, 0, 0, 0, 0, 1);
    chk_all("rst.trap", 32'h0, 0, 32'h0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk_all("rst.hold", 32'h0, 1, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
